// File: rtl/ternary_pipe_pkg.sv
// Shared types and constants for the ternary pipeline controller.
// Trits are 2-bit codes; widths of the pipeline-register structs are fixed here.
`ifndef T_ZERO
`define T_ZERO 2'b00
`endif

package ternary_pipe_pkg;

  localparam int TRIT_W          = 2;
  localparam int REG_ADDR_W      = 6;
  localparam int DEF_PC_TRITS    = 9;
  localparam int DEF_INSTR_TRITS = 9;
  localparam int PC_W            = DEF_PC_TRITS * TRIT_W;
  localparam int INSTR_W         = DEF_INSTR_TRITS * TRIT_W;

  typedef enum logic [1:0] {
    TRIT_ZERO = `T_ZERO,
    TRIT_POS  = 2'b01,
    TRIT_NEG  = 2'b10
  } trit_e;

  localparam logic [REG_ADDR_W-1:0] R0 = {3{`T_ZERO}};

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_id_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } id_ex_t;

  function automatic if_id_t bubble_if_id();
    if_id_t b;
    b.valid = 1'b0;
    b.pc    = {DEF_PC_TRITS{`T_ZERO}};
    b.instr = {DEF_INSTR_TRITS{`T_ZERO}};
    return b;
  endfunction

  function automatic id_ex_t bubble_id_ex();
    id_ex_t b;
    b.valid     = 1'b0;
    b.rd        = R0;
    b.reg_write = 1'b0;
    b.mem_read  = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ternary_pipe_ctrl_if.sv
// Hazard-request and pipeline-register bundle between the hazard/decode side
// (master) and the pipeline controller (slave).
interface ternary_pipe_ctrl_if
  import ternary_pipe_pkg::*;
#(
  parameter int PC_TRITS    = DEF_PC_TRITS,
  parameter int INSTR_TRITS = DEF_INSTR_TRITS,
  parameter int CNT_W       = 16
);

  logic                     pc_stall;
  logic                     if_id_stall;
  logic                     id_ex_flush;
  logic                     branch_taken;
  logic                     if_valid;
  logic [2*PC_TRITS-1:0]    if_pc;
  logic [2*INSTR_TRITS-1:0] if_instr;
  logic [REG_ADDR_W-1:0]    id_rd;
  logic                     id_reg_write;
  logic                     id_mem_read;

  logic                     pc_en;
  logic                     id_valid;
  logic [2*PC_TRITS-1:0]    id_pc;
  logic [2*INSTR_TRITS-1:0] id_instr;
  logic                     ex_valid;
  logic [REG_ADDR_W-1:0]    ex_rd;
  logic                     ex_reg_write;
  logic                     ex_mem_read;
  logic [CNT_W-1:0]         stall_cnt;
  logic                     stall_timeout;
  logic                     protocol_err;

  modport master (
    output pc_stall, if_id_stall, id_ex_flush, branch_taken,
    output if_valid, if_pc, if_instr, id_rd, id_reg_write, id_mem_read,
    input  pc_en, id_valid, id_pc, id_instr, ex_valid, ex_rd,
    input  ex_reg_write, ex_mem_read, stall_cnt, stall_timeout, protocol_err
  );

  modport slave (
    input  pc_stall, if_id_stall, id_ex_flush, branch_taken,
    input  if_valid, if_pc, if_instr, id_rd, id_reg_write, id_mem_read,
    output pc_en, id_valid, id_pc, id_instr, ex_valid, ex_rd,
    output ex_reg_write, ex_mem_read, stall_cnt, stall_timeout, protocol_err
  );

endinterface

// File: rtl/ternary_stall_monitor.sv
// Stall statistics and fault flags: saturating stall counter, consecutive-stall
// watchdog, and a sticky flag for disagreeing hazard requests.
module ternary_stall_monitor #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_stall,
  input  logic             if_id_stall,
  input  logic             id_ex_flush,
  input  logic             branch_taken,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout,
  output logic             protocol_err
);

  localparam int                 CONS_W = $clog2(MAX_STALL + 2);
  localparam logic [CONS_W-1:0]  CONS_LIMIT = CONS_W'(MAX_STALL);

  logic              eff_stall;
  logic              mismatch;
  logic [CONS_W-1:0] consec;
  logic [CONS_W-1:0] consec_next;

  // A redirect overrides any stall, so it neither counts nor disagrees.
  always_comb begin
    eff_stall   = (pc_stall | if_id_stall) & ~branch_taken;
    mismatch    = ~branch_taken &
                  ~((pc_stall == if_id_stall) && (if_id_stall == id_ex_flush));
    consec_next = '0;
    if (eff_stall) begin
      consec_next = (consec == {CONS_W{1'b1}}) ? consec : consec + CONS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt     <= '0;
      consec        <= '0;
      stall_timeout <= 1'b0;
      protocol_err  <= 1'b0;
    end else begin
      consec <= consec_next;
      if (eff_stall && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (consec_next > CONS_LIMIT) begin
        stall_timeout <= 1'b1;
      end
      if (mismatch) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ternary_pipe_ctrl.sv
// IF/ID and ID/EX pipeline registers with stall, flush and branch-redirect
// handling; pc_en is the only combinational output.
module ternary_pipe_ctrl
  import ternary_pipe_pkg::*;
#(
  parameter int PC_TRITS    = DEF_PC_TRITS,
  parameter int INSTR_TRITS = DEF_INSTR_TRITS,
  parameter int CNT_W       = 16,
  parameter int MAX_STALL   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ternary_pipe_ctrl_if.slave  bus
);

  logic [2*PC_TRITS-1:0]    pc_in;
  logic [2*INSTR_TRITS-1:0] instr_in;
  if_id_t                   if_id_d;
  if_id_t                   if_id_q;
  id_ex_t                   id_ex_d;
  id_ex_t                   id_ex_q;

  assign pc_in    = bus.if_pc;
  assign instr_in = bus.if_instr;

  // Invalid slots are turned into proper bubbles before entering ID/EX.
  always_comb begin
    if_id_d.valid     = bus.if_valid;
    if_id_d.pc        = pc_in;
    if_id_d.instr     = instr_in;
    id_ex_d.valid     = if_id_q.valid;
    id_ex_d.rd        = if_id_q.valid ? bus.id_rd : R0;
    id_ex_d.reg_write = bus.id_reg_write & if_id_q.valid;
    id_ex_d.mem_read  = bus.id_mem_read & if_id_q.valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_q <= bubble_if_id();
      id_ex_q <= bubble_id_ex();
    end else begin
      if (bus.branch_taken) begin
        if_id_q <= bubble_if_id();
      end else if (!bus.if_id_stall) begin
        if_id_q <= if_id_d;
      end
      if (bus.branch_taken || bus.id_ex_flush) begin
        id_ex_q <= bubble_id_ex();
      end else begin
        id_ex_q <= id_ex_d;
      end
    end
  end

  assign bus.pc_en        = rst_n & (bus.branch_taken | ~bus.pc_stall);
  assign bus.id_valid     = if_id_q.valid;
  assign bus.id_pc        = if_id_q.pc;
  assign bus.id_instr     = if_id_q.instr;
  assign bus.ex_valid     = id_ex_q.valid;
  assign bus.ex_rd        = id_ex_q.rd;
  assign bus.ex_reg_write = id_ex_q.reg_write;
  assign bus.ex_mem_read  = id_ex_q.mem_read;

  ternary_stall_monitor #(
    .CNT_W     (CNT_W),
    .MAX_STALL (MAX_STALL)
  ) u_monitor (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_stall      (bus.pc_stall),
    .if_id_stall   (bus.if_id_stall),
    .id_ex_flush   (bus.id_ex_flush),
    .branch_taken  (bus.branch_taken),
    .stall_cnt     (bus.stall_cnt),
    .stall_timeout (bus.stall_timeout),
    .protocol_err  (bus.protocol_err)
  );

endmodule
